// File: rtl/rv32_pkg.sv
// Shared RV32I decode constants and the ALU operation encoding used by the
// issue stage and the ALU it feeds.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]      alu_op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            rd_wren;
    logic            illegal;
  } issue_t;

  // i_alt selects SUB/SRA over ADD/SRL; it is only meaningful for funct3 000/101
  function automatic logic [3:0] alu_op_from_f3(input logic [2:0] i_f3, input logic i_alt);
    logic [3:0] r_op;
    case (i_f3)
      F3_ADD_SUB: r_op = i_alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     r_op = ALU_SLL;
      F3_SLT:     r_op = ALU_SLT;
      F3_SLTU:    r_op = ALU_SLTU;
      F3_XOR:     r_op = ALU_XOR;
      F3_SRL_SRA: r_op = i_alt ? ALU_SRA : ALU_SRL;
      F3_OR:      r_op = ALU_OR;
      default:    r_op = ALU_AND;
    endcase
    return r_op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: picks the I, S or U format from the
// opcode and sign-extends from instruction bit 31.
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [31:0] o_imm
);

  logic [6:0]  w_opcode;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_u;

  assign w_opcode = i_instr[6:0];
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_u  = {i_instr[31:12], 12'b0};

  always_comb begin
    o_imm = '0;
    case (w_opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: o_imm = w_imm_i;
      OPC_STORE:                      o_imm = w_imm_s;
      OPC_LUI, OPC_AUIPC:             o_imm = w_imm_u;
      default:                        o_imm = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes an RV32I instruction into ALU op and operands and
// holds the result in a single valid/ready pipeline slot with flush.
module alu_issue_stage
  import rv32_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_operand_a,
  output logic [31:0] o_operand_b,
  output logic [3:0]  o_alu_op,
  output logic [4:0]  o_rd_addr,
  output logic        o_rd_wren,
  output logic        o_illegal
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd_addr;
  logic [31:0] w_imm;
  logic [31:0] w_shamt;
  logic        w_accept;
  issue_t      w_dec;

  logic        r_valid;
  logic [4:0]  r_rd_addr;
  issue_t      r_entry;

  assign w_opcode  = i_instr[6:0];
  assign w_rd_addr = i_instr[11:7];
  assign w_funct3  = i_instr[14:12];
  assign w_funct7  = i_instr[31:25];
  assign w_shamt   = {27'b0, i_instr[24:20]};

  imm_gen u_imm_gen (
    .i_instr (i_instr),
    .o_imm   (w_imm)
  );

  // Operands are only driven on legal paths so an illegal entry carries A=B=0.
  always_comb begin
    w_dec        = '0;
    w_dec.alu_op = ALU_ADD;
    case (w_opcode)
      OPC_OP: begin
        if (w_funct7 == F7_BASE ||
            (w_funct7 == F7_ALT && (w_funct3 == F3_ADD_SUB || w_funct3 == F3_SRL_SRA))) begin
          w_dec.operand_a = i_rs1_data;
          w_dec.operand_b = i_rs2_data;
          w_dec.alu_op    = alu_op_from_f3(w_funct3, w_funct7[5]);
          w_dec.rd_wren   = 1'b1;
        end else begin
          w_dec.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        if (w_funct3 == F3_SLL) begin
          if (w_funct7 == F7_BASE) begin
            w_dec.operand_a = i_rs1_data;
            w_dec.operand_b = w_shamt;
            w_dec.alu_op    = ALU_SLL;
            w_dec.rd_wren   = 1'b1;
          end else begin
            w_dec.illegal = 1'b1;
          end
        end else if (w_funct3 == F3_SRL_SRA) begin
          if (w_funct7 == F7_BASE || w_funct7 == F7_ALT) begin
            w_dec.operand_a = i_rs1_data;
            w_dec.operand_b = w_shamt;
            w_dec.alu_op    = (w_funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            w_dec.rd_wren   = 1'b1;
          end else begin
            w_dec.illegal = 1'b1;
          end
        end else begin
          w_dec.operand_a = i_rs1_data;
          w_dec.operand_b = w_imm;
          w_dec.alu_op    = alu_op_from_f3(w_funct3, 1'b0);
          w_dec.rd_wren   = 1'b1;
        end
      end
      OPC_LUI: begin
        w_dec.operand_b = w_imm;
        w_dec.rd_wren   = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.operand_a = i_pc;
        w_dec.operand_b = w_imm;
        w_dec.rd_wren   = 1'b1;
      end
      OPC_JAL: begin
        w_dec.operand_a = i_pc;
        w_dec.operand_b = 32'd4;
        w_dec.rd_wren   = 1'b1;
      end
      OPC_JALR: begin
        if (w_funct3 == 3'b000) begin
          w_dec.operand_a = i_pc;
          w_dec.operand_b = 32'd4;
          w_dec.rd_wren   = 1'b1;
        end else begin
          w_dec.illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        w_dec.operand_a = i_rs1_data;
        w_dec.operand_b = i_rs2_data;
        case (w_funct3)
          F3_BEQ, F3_BNE:   w_dec.alu_op = ALU_SUB;
          F3_BLT, F3_BGE:   w_dec.alu_op = ALU_SLT;
          F3_BLTU, F3_BGEU: w_dec.alu_op = ALU_SLTU;
          default: begin
            w_dec.operand_a = '0;
            w_dec.operand_b = '0;
            w_dec.illegal   = 1'b1;
          end
        endcase
      end
      OPC_LOAD: begin
        if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111) begin
          w_dec.illegal = 1'b1;
        end else begin
          w_dec.operand_a = i_rs1_data;
          w_dec.operand_b = w_imm;
          w_dec.rd_wren   = 1'b1;
        end
      end
      OPC_STORE: begin
        if (w_funct3[2] || w_funct3 == 3'b011) begin
          w_dec.illegal = 1'b1;
        end else begin
          w_dec.operand_a = i_rs1_data;
          w_dec.operand_b = w_imm;
        end
      end
      default: w_dec.illegal = 1'b1;
    endcase
    if (w_rd_addr == 5'd0) begin
      w_dec.rd_wren = 1'b0;
    end
  end

  assign o_ready  = !r_valid || i_ready;
  assign w_accept = i_valid && o_ready;

  // Flush wins over both accept and hold, and scrubs the payload as well.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid   <= 1'b0;
      r_entry   <= '0;
      r_rd_addr <= '0;
    end else if (i_flush) begin
      r_valid   <= 1'b0;
      r_entry   <= '0;
      r_rd_addr <= '0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_entry   <= w_dec;
      r_rd_addr <= w_rd_addr;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid     = r_valid;
  assign o_operand_a = r_entry.operand_a;
  assign o_operand_b = r_entry.operand_b;
  assign o_alu_op    = r_entry.alu_op;
  assign o_rd_addr   = r_rd_addr;
  assign o_rd_wren   = r_entry.rd_wren;
  assign o_illegal   = r_entry.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed, table-driven bench for alu_issue_stage: decode vectors in a loop
// plus hand-written stall, flush and async-reset sequences.
module tb_alu_issue_stage;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] expA;
    logic [31:0] expB;
    logic [3:0]  expOp;
    logic [4:0]  expRd;
    logic        expWren;
    logic        expIll;
  } vec_t;

  logic        clk;
  logic        rstN;
  logic        flush;
  logic        inValid;
  logic        outReady;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic        outValid;
  logic        inReady;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [3:0]  aluOp;
  logic [4:0]  rdAddr;
  logic        rdWren;
  logic        illegal;

  int errors = 0;
  int checks = 0;
  vec_t vecs[15];

  alu_issue_stage dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_flush     (flush),
    .i_valid     (inValid),
    .o_ready     (outReady),
    .i_instr     (instr),
    .i_pc        (pc),
    .i_rs1_data  (rs1Data),
    .i_rs2_data  (rs2Data),
    .o_valid     (outValid),
    .i_ready     (inReady),
    .o_operand_a (operandA),
    .o_operand_b (operandB),
    .o_alu_op    (aluOp),
    .o_rd_addr   (rdAddr),
    .o_rd_wren   (rdWren),
    .o_illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input logic valid, input logic ready, input logic fl);
    instr   = v.instr;
    pc      = v.pc;
    rs1Data = v.rs1;
    rs2Data = v.rs2;
    inValid = valid;
    inReady = ready;
    flush   = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkEntry(input vec_t v);
    checkOutput({v.name, ".valid"}, {31'b0, outValid}, 32'd1);
    checkOutput({v.name, ".a"}, operandA, v.expA);
    checkOutput({v.name, ".b"}, operandB, v.expB);
    checkOutput({v.name, ".op"}, {28'b0, aluOp}, {28'b0, v.expOp});
    checkOutput({v.name, ".rd"}, {27'b0, rdAddr}, {27'b0, v.expRd});
    checkOutput({v.name, ".wren"}, {31'b0, rdWren}, {31'b0, v.expWren});
    checkOutput({v.name, ".ill"}, {31'b0, illegal}, {31'b0, v.expIll});
  endtask

  task automatic checkCleared(input string name);
    checkOutput({name, ".valid"}, {31'b0, outValid}, 32'd0);
    checkOutput({name, ".a"}, operandA, 32'd0);
    checkOutput({name, ".b"}, operandB, 32'd0);
    checkOutput({name, ".op"}, {28'b0, aluOp}, 32'd0);
    checkOutput({name, ".rd"}, {27'b0, rdAddr}, 32'd0);
    checkOutput({name, ".wren"}, {31'b0, rdWren}, 32'd0);
    checkOutput({name, ".ill"}, {31'b0, illegal}, 32'd0);
  endtask

  initial begin
    //              name       instr         pc            rs1           rs2           A             B             op     rd     wren  ill
    vecs[0]  = '{"add",      32'h002081B3, 32'h0,        32'd5,        32'd7,        32'd5,        32'd7,        4'd0, 5'd3,  1'b1, 1'b0};
    vecs[1]  = '{"srai",     32'h4030D213, 32'h0,        32'h80000000, 32'd0,        32'h80000000, 32'd3,        4'd9, 5'd4,  1'b1, 1'b0};
    vecs[2]  = '{"lui",      32'h123452B7, 32'h0,        32'h11,       32'h22,       32'd0,        32'h12345000, 4'd0, 5'd5,  1'b1, 1'b0};
    vecs[3]  = '{"jal",      32'h000000EF, 32'h100,      32'h11,       32'h22,       32'h100,      32'd4,        4'd0, 5'd1,  1'b1, 1'b0};
    vecs[4]  = '{"ill_opc",  32'h000000FF, 32'h0,        32'h11,       32'h22,       32'd0,        32'd0,        4'd0, 5'd1,  1'b0, 1'b1};
    vecs[5]  = '{"ill_f7",   32'h4020F1B3, 32'h0,        32'h11,       32'h22,       32'd0,        32'd0,        4'd0, 5'd3,  1'b0, 1'b1};
    vecs[6]  = '{"addi_x0",  32'h00100013, 32'h0,        32'd0,        32'd0,        32'd0,        32'd1,        4'd0, 5'd0,  1'b0, 1'b0};
    vecs[7]  = '{"sub",      32'h402081B3, 32'h0,        32'd9,        32'd4,        32'd9,        32'd4,        4'd1, 5'd3,  1'b1, 1'b0};
    vecs[8]  = '{"addi_neg", 32'hFFF08313, 32'h0,        32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, 4'd0, 5'd6,  1'b1, 1'b0};
    vecs[9]  = '{"auipc",    32'hFFFFF397, 32'h2000,     32'h11,       32'h22,       32'h2000,     32'hFFFFF000, 4'd0, 5'd7,  1'b1, 1'b0};
    vecs[10] = '{"sw",       32'hFE20AE23, 32'h0,        32'h400,      32'h55,       32'h400,      32'hFFFFFFFC, 4'd0, 5'd28, 1'b0, 1'b0};
    vecs[11] = '{"bltu",     32'h0020E063, 32'h0,        32'd3,        32'd8,        32'd3,        32'd8,        4'd3, 5'd0,  1'b0, 1'b0};
    vecs[12] = '{"srli_bad", 32'h0230D213, 32'h0,        32'h11,       32'h22,       32'd0,        32'd0,        4'd0, 5'd4,  1'b0, 1'b1};
    vecs[13] = '{"jalr",     32'h000100E7, 32'h40,       32'h11,       32'h22,       32'h40,       32'd4,        4'd0, 5'd1,  1'b1, 1'b0};
    vecs[14] = '{"lw",       32'h0080A403, 32'h0,        32'h300,      32'h22,       32'h300,      32'd8,        4'd0, 5'd8,  1'b1, 1'b0};

    rstN = 1'b0;
    applyStimulus(vecs[0], 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    checkCleared("in_reset");
    rstN = 1'b1;
    tick();
    checkCleared("idle");
    checkOutput("idle.ready", {31'b0, outReady}, 32'd1);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i], 1'b1, 1'b1, 1'b0);
      tick();
      checkEntry(vecs[i]);
      checkOutput({vecs[i].name, ".ready"}, {31'b0, outReady}, 32'd1);
    end
    inValid = 1'b0;
    tick();
    checkOutput("drain.valid", {31'b0, outValid}, 32'd0);

    // Stall: first entry held while a second is offered, then back-to-back
    applyStimulus(vecs[0], 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(vecs[7], 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("stall.ready", {31'b0, outReady}, 32'd0);
    tick();
    checkEntry(vecs[0]);
    checkOutput("stall.ready2", {31'b0, outReady}, 32'd0);
    tick();
    checkEntry(vecs[0]);
    inReady = 1'b1;
    #1;
    checkOutput("release.ready", {31'b0, outReady}, 32'd1);
    tick();
    checkEntry(vecs[7]);
    inValid = 1'b0;
    tick();
    checkOutput("drain2.valid", {31'b0, outValid}, 32'd0);

    // Flush while stalled on an illegal entry with a new one offered
    applyStimulus(vecs[4], 1'b1, 1'b1, 1'b0);
    tick();
    checkEntry(vecs[4]);
    applyStimulus(vecs[7], 1'b1, 1'b0, 1'b1);
    tick();
    checkCleared("flush");
    applyStimulus(vecs[7], 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("post_flush.valid", {31'b0, outValid}, 32'd0);

    // Async reset in the middle of a stall
    applyStimulus(vecs[0], 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(vecs[7], 1'b1, 1'b0, 1'b0);
    tick();
    checkEntry(vecs[0]);
    #2;
    rstN = 1'b0;
    #1;
    checkCleared("async_rst");
    inValid = 1'b0;
    tick();
    rstN = 1'b1;
    tick();
    checkOutput("after_rst.valid", {31'b0, outValid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/issue pipeline stage that sits directly in front of the ALU. It accepts a fetched RV32I instruction together with its register-file read data and PC. It decodes the instruction into the ALU's 4-bit operation code and its two 32-bit operands, and holds them in a registered ID/EX slot. A valid/ready handshake on both sides supports stall and flush.

## Interface
Parameters:
- none. Data width is fixed at 32 and the ALU op width at 4, to match the ALU.

Ports:
- i_clk, in, 1: single clock; all state updates on the rising edge.
- i_rst_n, in, 1: reset, asynchronous and active-low.
- i_flush, in, 1: kills the held entry and any entry being accepted this cycle.
- i_valid, in, 1: upstream offers an instruction.
- o_ready, out, 1: stage can accept this cycle.
- i_instr, in, 32: RV32I instruction word.
- i_pc, in, 32: PC of i_instr.
- i_rs1_data, in, 32: register-file read data for rs1.
- i_rs2_data, in, 32: register-file read data for rs2.
- o_valid, out, 1: registered entry is valid.
- i_ready, in, 1: ALU/EX consumes the entry this cycle.
- o_operand_a, out, 32: ALU operand A.
- o_operand_b, out, 32: ALU operand B.
- o_alu_op, out, 4: ALU operation code.
- o_rd_addr, out, 5: destination register.
- o_rd_wren, out, 1: writeback enable.
- o_illegal, out, 1: unsupported or illegal encoding.

## Operation
ALU op codes are fixed: ADD=0, SUB=1, SLT=2, SLTU=3, XOR=4, OR=5, AND=6, SLL=7, SRL=8, SRA=9.

Decode by opcode:
- OP (0110011), valid R-type: A=rs1, B=rs2. funct3/funct7 map to the ALU op. funct7=0100000 is allowed only with funct3 000 (SUB) and 101 (SRA). rd_wren=1.
- OP-IMM (0010011): A=rs1, B=sign-extended I-imm.
  - Shifts: B={27'b0, shamt}. funct7 must be 0000000, except SRAI, which requires 0100000.
  - There is no SUBI: funct3 000 is ADD.
  - rd_wren=1.
- LUI: A=0, B=U-imm, op ADD, rd_wren=1.
- AUIPC: A=pc, B=U-imm, op ADD, rd_wren=1.
- JAL / JALR: A=pc, B=4, op ADD, rd_wren=1 (computes the link address).
- BRANCH: A=rs1, B=rs2, rd_wren=0.
  - BEQ/BNE use SUB.
  - BLT/BGE use SLT.
  - BLTU/BGEU use SLTU.
- LOAD: A=rs1, B=I-imm, op ADD, rd_wren=1.
- STORE: A=rs1, B=S-imm, op ADD, rd_wren=0.
- Anything else: o_illegal=1, op ADD, A=B=0, rd_wren=0. The entry still flows so that EX can trap.
- rd_addr = instr[11:7]. If rd_addr=0, rd_wren is forced to 0.

## Timing
- Reset: o_valid=0, o_operand_a=0, o_operand_b=0, o_alu_op=0, o_rd_addr=0, o_rd_wren=0, o_illegal=0.
- Latency: 1 cycle. An instruction accepted at edge N appears on the outputs after edge N.
- o_ready = !o_valid || i_ready. It is combinational and does not depend on i_valid.
- Accept: i_valid && o_ready. On accept, all output registers load and o_valid becomes 1.
- Drain: o_valid && i_ready && !i_valid clears o_valid. Payload registers may hold stale values.
- Stall: o_valid && !i_ready. All outputs hold stable; no accept takes place.
- Simultaneous drain and accept: the new entry replaces the old one in the same cycle (full throughput).
- i_flush has priority over accept and hold: next o_valid=0. Payload and o_illegal are cleared to 0.
- Reset asserted mid-stall: outputs go to reset values immediately (asynchronously), and the entry is lost.
- Datapath has no arithmetic in this stage. Immediates are sign-extended from bit 31; U-imm = {instr[31:12], 12'b0}.

## Structure
- Shared package `rv32_pkg`:
  - ALU op localparams: ALU_ADD through ALU_SRA.
  - Opcode constants: OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE.
  - funct3 constants.
- Sub-module `imm_gen`: combinational generator for I/S/U immediates, selected by opcode.
- The decode block is combinational and feeds a single pipeline register block.

## Test plan
- Reset then idle: hold i_rst_n=0, then release with i_valid=0 → all outputs 0, o_ready=1.
- Decode checks (one accept each, i_ready=1):
  - ADD x3,x1,x2 with rs1=5, rs2=7 → alu_op=0, A=5, B=7, rd=3, wren=1.
  - SRAI x4,x1,3 (0x4030D213) → alu_op=9, B=3.
  - LUI x5,0x12345 → A=0, B=0x12345000, op=0.
  - JAL at pc=0x100 → A=0x100, B=4, op=0.
- Stall and back-to-back:
  - Two accepts with i_ready=0 after the first → second is held off, o_ready=0, first payload stable.
  - Raise i_ready → second instruction is accepted in the same cycle the first drains.
- Flush while stalled with i_valid=1 → next cycle o_valid=0 and the new instruction is dropped.
- Illegal cases:
  - Opcode 0x7F → o_illegal=1, wren=0.
  - R-type funct7=0100000 with funct3=111 → o_illegal=1.
  - ADDI x0,x0,1 → wren=0, illegal=0.
- Async reset asserted mid-stall with o_valid=1 → o_valid=0 before the next clock edge.
